// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes and FSM state encoding for alu_seq.
// Imported by alu_seq and alu_mul_seq.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_LOGIC = 3'b010;
    localparam logic [2:0] OP_ANY   = 3'b011;
    localparam logic [2:0] OP_ALL   = 3'b100;
    localparam logic [2:0] OP_MIX   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: WIDTH-bit shift-add multiplier engine, one iteration per step.
// Ports: clock, resetn, load (latch a/b, clear product), step (iterate),
//        a, b (operands), last (final iteration this cycle),
//        prod_nxt (product after the current iteration).
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   prod_nxt
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    logic [RW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [RW-1:0]    prod_q, prod_d;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        prod_nxt = prod_q + (mplr_q[0] ? mcand_q : '0);
        last     = step && (count_q == CW'(WIDTH - 1));
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        prod_d   = prod_q;
        count_d  = count_q;
        if (load) begin
            mcand_d = {{WIDTH{1'b0}}, a};
            mplr_d  = b;
            prod_d  = '0;
            count_d = '0;
        end else if (step) begin
            prod_d  = prod_nxt;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mcand_q <= '0;
            mplr_q  <= '0;
            prod_q  <= '0;
            count_q <= '0;
        end else begin
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            prod_q  <= prod_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/done handshake, accumulator feedback
// and optional multi-cycle multiply (macro ALU_MUL_EN).
// Ports: clock, resetn, start, op, acc_sel, a, b -> result (2*WIDTH), done,
//        busy, zero.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic                 acc_sel,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done,
    output logic                 busy,
    output logic                 zero
);

    localparam int RW = 2 * WIDTH;

    logic [RW-1:0]    result_q, result_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [RW-1:0]    alu_res;

    // B is resolved from the result register as it stands before the edge
    always_comb begin
        b_eff   = acc_sel ? result_q[WIDTH-1:0] : b;
        sum     = {1'b0, a} + {1'b0, b_eff};
        // extra MSB of the difference is the unsigned borrow
        dif     = {1'b0, a} - {1'b0, b_eff};
        alu_res = '0;
        unique case (op)
            OP_ADD:   alu_res = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB:   alu_res = {{(WIDTH-1){1'b0}}, dif};
            OP_LOGIC: alu_res = {a ^ b_eff, a | b_eff};
            OP_ANY: begin
                if (|{a, b_eff}) begin
                    alu_res[RW-1] = 1'b1;
                    alu_res[0]    = 1'b1;
                end
            end
            OP_ALL: begin
                if (&{a, b_eff}) alu_res[RW-2:1] = '1;
            end
            OP_MIX:   alu_res = {~a, b_eff};
            OP_MUL:   alu_res = '0;
            OP_NOP:   alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    state_t        state_q, state_d;
    logic          busy_q, busy_d;
    logic          mul_load;
    logic          mul_step;
    logic          mul_last;
    logic [RW-1:0] mul_prod;

    assign mul_load = (state_q == S_IDLE) && start && (op == OP_MUL);
    assign mul_step = (state_q == S_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock    (clock),
        .resetn   (resetn),
        .load     (mul_load),
        .step     (mul_step),
        .a        (a),
        .b        (b_eff),
        .last     (mul_last),
        .prod_nxt (mul_prod)
    );

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        result_d = result_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        state_d = S_MUL;
                        busy_d  = 1'b1;
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                        zero_d   = (alu_res == '0);
                    end
                end
            end
            S_MUL: begin
                // start is ignored here; it is not queued
                if (mul_last) begin
                    state_d  = S_IDLE;
                    busy_d   = 1'b0;
                    result_d = mul_prod;
                    done_d   = 1'b1;
                    zero_d   = (mul_prod == '0);
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
        end
    end

    assign busy = busy_q;
`else
    // without the multiplier, opcode 110 is a one-cycle write of zero
    always_comb begin
        result_d = result_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        if (start) begin
            result_d = alu_res;
            done_d   = 1'b1;
            zero_d   = (alu_res == '0);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            result_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
        end
    end

    assign busy = 1'b0;
`endif

    assign result = result_q;
    assign done   = done_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (WIDTH=4) against a
// behavioural model; handles builds with and without ALU_MUL_EN.
module tb_alu_seq;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic       acc_sel = 1'b0;
    logic [3:0] a = 4'd0;
    logic [3:0] b = 4'd0;
    logic [7:0] result;
    logic       done;
    logic       busy;
    logic       zero;

    int checks = 0;
    int failures = 0;
    int exp_res = 0;

    alu_seq #(.WIDTH(4)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .op      (op),
        .acc_sel (acc_sel),
        .a       (a),
        .b       (b),
        .result  (result),
        .done    (done),
        .busy    (busy),
        .zero    (zero)
    );

    always #5 clock = ~clock;

    function automatic int model(input int o, input int x, input int y);
        case (o)
            0: return x + y;
            1: return (x >= y) ? (x - y) : (x - y + 32);
            2: return ((x ^ y) * 16) + (x | y);
            3: return ((x | y) != 0) ? 'h81 : 0;
            4: return (x == 15 && y == 15) ? 'h7E : 0;
            5: return ((15 - x) * 16) + y;
`ifdef ALU_MUL_EN
            6: return x * y;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op; check latency, busy, done, result and zero.
    task automatic do_op(input int o, input int av, input int bv,
                         input int acc);
        int bb;
        int e;
        bb = (acc != 0) ? (exp_res % 16) : bv;
        e = model(o, av, bb);
        op = 3'(o);
        a = 4'(av);
        b = 4'(bv);
        acc_sel = (acc != 0);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
`ifdef ALU_MUL_EN
        if (o == 6) begin
            for (int i = 0; i < 4; i++) begin
                chk("mul_busy", int'(busy), 1);
                chk("mul_done_early", int'(done), 0);
                chk("mul_result_hold", int'(result), exp_res);
                // a start during busy must be ignored
                op = 3'd0;
                a = 4'($urandom_range(15));
                start = 1'b1;
                @(posedge clock);
                #1;
            end
            start = 1'b0;
        end
`endif
        chk("done", int'(done), 1);
        chk("busy_at_done", int'(busy), 0);
        chk("result", int'(result), e);
        chk("zero", int'(zero), (e == 0) ? 1 : 0);
        exp_res = e;
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
        chk("idle_done", int'(done), 0);
        chk("idle_result", int'(result), exp_res);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk("rst_result", int'(result), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_zero", int'(zero), 1);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        do_op(0, 9, 8, 0);
        chk("add_val", int'(result), 'h11);
        idle_cycle();
        do_op(1, 3, 5, 0);
        chk("sub_borrow", int'(result), 'h1E);
        do_op(1, 5, 5, 0);
        chk("sub_zero", int'(zero), 1);
        do_op(2, 'hA, 'h5, 0);
        chk("logic_ff", int'(result), 'hFF);
        do_op(4, 15, 15, 0);
        do_op(3, 0, 0, 0);
        idle_cycle();

        do_op(6, 15, 15, 0);
`ifdef ALU_MUL_EN
        chk("mul_ff", int'(result), 'hE1);
`else
        chk("op6_nop", int'(result), 0);
`endif
        idle_cycle();

        do_op(0, 7, 0, 0);
        do_op(0, 1, 0, 1);
        chk("acc_8", int'(result), 'h08);
        do_op(0, 2, 0, 1);
        chk("acc_a", int'(result), 'h0A);
        idle_cycle();

        // reset two cycles into a multiply (or an idle pulse without it)
        op = 3'd6;
        a = 4'd6;
        b = 4'd7;
        acc_sel = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b0;
        #1;
        chk("mrst_result", int'(result), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_zero", int'(zero), 1);
        exp_res = 0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        idle_cycle();
        idle_cycle();
        do_op(6, 6, 7, 0);

        for (int n = 0; n < 60; n++) begin
            do_op(int'($urandom_range(7)), int'($urandom_range(15)),
                  int'($urandom_range(15)), int'($urandom_range(1)));
            if ($urandom_range(3) == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, clocked successor to the lab's 4-bit combinational ALU. It registers operands and results, adds a start/done handshake and a multi-cycle shift-add multiplier, and can feed its previous result back as operand B (accumulator mode). It sits between the switch/key input logic and the LEDR/HEX display decoders of a lab top level, and drives a 2×WIDTH result bus.

## Interface
- WIDTH, 4, operand width in bits; minimum 2; result is 2×WIDTH.
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  3  opcode, sampled with start
- acc_sel  in  1  1 = operand B is result[WIDTH-1:0]; 0 = b input; sampled with start
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- result  out  2×WIDTH  registered result; holds until the next completed operation
- done  out  1  one-cycle pulse when result updates
- busy  out  1  high while a multiply is in progress
- zero  out  1  registered; 1 when the last written result is all zeros

## Operation
- Opcodes, with zero-extension to 2×WIDTH unless stated:
  - 000 ADD: {carry, A+B}
  - 001 SUB: {borrow, A−B mod 2^WIDTH}; borrow is 1 iff A<B (unsigned)
  - 010 LOGIC: {A^B, A|B}
  - 011 ANY: MSB and LSB set if any bit of A or B is 1; else 0
  - 100 ALL: bits [2W−2:1] set if every bit of A and B is 1; else 0
  - 101 MIX: {~A, B}
  - 110 MUL: unsigned A×B, full 2×WIDTH product
  - 111: result 0
- FSM states:
  - IDLE: on start with op≠110, compute and write result, pulse done, stay IDLE. On start with op=110, latch operands, clear the partial product, set count=0, go to MUL.
  - MUL: each cycle, if multiplier LSB=1 add the shifted multiplicand to the partial product, then shift, count++. After WIDTH iterations, write result, pulse done, return to IDLE.
- Operand B is resolved at acceptance. With acc_sel=1, B is the result value present before the accepting edge.
- zero updates on every result write.

## Timing
- Reset values: result=0, done=0, busy=0, zero=1, state IDLE, count=0. Reset asserted mid-multiply aborts the operation with no done pulse.
- Single-cycle ops: start high in cycle c → result and done valid in cycle c+1.
- MUL: start in cycle c → busy high in cycles c+1..c+WIDTH → result and done in cycle c+WIDTH+1, with busy=0 in that cycle.
- start while busy=1 is ignored entirely; it is not queued.
- start in the same cycle as done (busy=0) is accepted, which allows back-to-back ops at one per cycle.
- done is never high for two consecutive cycles unless a new op was accepted in the intervening edge.
- result changes only on the cycle done goes high.

## Configuration
- ALU_MUL_EN defined: opcode 110 performs the multi-cycle multiply as specified.
- ALU_MUL_EN undefined: the multiplier datapath and MUL state are not compiled. Opcode 110 behaves like 111: result 0, latency 1, busy tied to 0.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_LOGIC, OP_ANY, OP_ALL, OP_MIX, OP_MUL, OP_NOP
  - state encoding: S_IDLE, S_MUL
- One sub-module, alu_mul_seq: a WIDTH-parametrised shift-add engine with load/step/last signals and the count register, instantiated only under ALU_MUL_EN.
- Single-cycle ops are combinational inside alu_seq, registered at the result write.

## Test plan
- WIDTH=4, ADD a=9 b=8 → result 0x11 and done one cycle after start; zero=0.
- SUB a=3 b=5 → result 0x1E (borrow=1, low nibble 0xE); SUB a=5 b=5 → 0x00 with zero=1.
- MUL a=15 b=15 → busy high for exactly 4 cycles, then result 0xE1 and done in cycle start+5. A start with op=000 issued during busy is ignored and result stays 0xE1.
- Accumulator sequence:
  - ADD a=7 b=0 → 0x07
  - ADD a=1 acc_sel=1 → 0x08
  - next-cycle back-to-back ADD a=2 acc_sel=1 → 0x0A; done high in both cycles.
- Reset pulse two cycles into MUL a=6 b=7 → result 0, busy 0, no done pulse. A subsequent MUL 6×7 → 0x2A.
- Build without ALU_MUL_EN: op=110 a=3 b=3 → result 0x00, done at start+1, busy never asserts. LOGIC a=0xA b=0x5 → 0xFF.
